// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the PLL lock sequencer.
package pll_ctrl_pkg;

    // Sequencer states; the encoding is visible on the debug state output.
    typedef enum logic [2:0] {
        RESET     = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        RETRY     = 3'd4,
        FAIL      = 3'd5
    } pll_state_t;

    localparam int unsigned RETRY_CNT_W   = 8;
    localparam logic [RETRY_CNT_W-1:0] RETRY_CNT_SAT = '1;

    // Width of the shared phase counter: it only ever has to reach (largest window - 1).
    function automatic int unsigned cnt_width(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 2) return 1;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level signal.
module cdc_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain; cleared to 0 on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock sequencer: pulses the PLL reset, qualifies LOCK as stable, releases
// clk_ready, and re-resets the PLL with bounded retries on lock loss or lock timeout.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYC     = 100,
    parameter int unsigned LOCK_STABLE_CYC  = 1024,
    parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
    parameter int unsigned MAX_RETRY        = 7,
    parameter int unsigned SYNC_STAGES      = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pll_lock,
    input  logic                   soft_rst_req,
    output logic                   pll_rst,
    output logic                   clk_ready,
    output logic                   lock_lost,
    output logic [RETRY_CNT_W-1:0] retry_cnt,
    output logic                   pll_fail,
    output logic [2:0]             state_o
);

    localparam int unsigned CW = cnt_width(RST_HOLD_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC);

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_HOLD_CYC - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);

    localparam bit                     RETRY_FOREVER = (MAX_RETRY == 0);
    localparam logic [RETRY_CNT_W-1:0] RETRY_LIMIT   = RETRY_CNT_W'(MAX_RETRY);

    pll_state_t             state_q;
    pll_state_t             state_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic [RETRY_CNT_W-1:0] retry_q;
    logic [RETRY_CNT_W-1:0] retry_d;
    logic                   lost_d;
    logic                   lock_s;

    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    // State, shared phase counter and registered outputs; outputs are decoded from the
    // next state so they change on the same edge as the state itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RESET;
            cnt_q     <= '0;
            retry_q   <= '0;
            pll_rst   <= 1'b1;
            clk_ready <= 1'b0;
            lock_lost <= 1'b0;
            pll_fail  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst   <= (state_d == RESET) || (state_d == FAIL);
            clk_ready <= (state_d == RUN);
            lock_lost <= lost_d;
            pll_fail  <= (state_d == FAIL);
        end
    end

    // Next-state, counter and retry bookkeeping; a soft restart overrides every other event.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        lost_d  = 1'b0;

        if (soft_rst_req) begin
            state_d = RESET;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                RESET: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d = RETRY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                // A lock drop, even on the terminal cycle, sends us back to wait without
                // charging a retry; the timeout window restarts from zero.
                STABLE: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                RUN: begin
                    if (!lock_s) begin
                        state_d = RETRY;
                        lost_d  = 1'b1;
                    end
                end

                RETRY: begin
                    cnt_d = '0;
                    if (!RETRY_FOREVER && (retry_q == RETRY_LIMIT)) begin
                        state_d = FAIL;
                    end else begin
                        state_d = RESET;
                        if (retry_q != RETRY_CNT_SAT) begin
                            retry_d = retry_q + 1'b1;
                        end
                    end
                end

                FAIL: begin
                    state_d = FAIL;
                end

                default: begin
                    state_d = RESET;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign retry_cnt = retry_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Self-checking bench for pll_lock_ctrl: scenario-driven, with expected values queued
// when stimulus is applied and compared when the DUT responds.
module tb_pll_lock_ctrl;
    import pll_ctrl_pkg::*;

    localparam int RST_HOLD_CYC     = 4;
    localparam int LOCK_STABLE_CYC  = 8;
    localparam int LOCK_TIMEOUT_CYC = 20;
    localparam int MAX_RETRY        = 2;
    localparam int SYNC_STAGES      = 2;

    localparam int W_RST_LO  = 0;
    localparam int W_RDY_HI  = 1;
    localparam int W_LOST_HI = 2;
    localparam int W_FAIL_HI = 3;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       soft_rst_req;
    logic       pll_rst;
    logic       clk_ready;
    logic       lock_lost;
    logic [7:0] retry_cnt;
    logic       pll_fail;
    logic [2:0] state_o;

    int n_vec;
    int n_err;
    int cyc;
    int ll_cnt;
    int rdy_rises;

    string sb_tag[$];
    int    sb_exp[$];

    pll_lock_ctrl #(
        .RST_HOLD_CYC     (RST_HOLD_CYC),
        .LOCK_STABLE_CYC  (LOCK_STABLE_CYC),
        .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC),
        .MAX_RETRY        (MAX_RETRY),
        .SYNC_STAGES      (SYNC_STAGES)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pll_lock     (pll_lock),
        .soft_rst_req (soft_rst_req),
        .pll_rst      (pll_rst),
        .clk_ready    (clk_ready),
        .lock_lost    (lock_lost),
        .retry_cnt    (retry_cnt),
        .pll_fail     (pll_fail),
        .state_o      (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge lock_lost) ll_cnt++;
    always @(posedge clk_ready) rdy_rises++;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic sb_push(input string tag, input int v);
        sb_tag.push_back(tag);
        sb_exp.push_back(v);
    endtask

    task automatic sb_pop(input int got);
        if (sb_exp.size() == 0) begin
            chk("sb_underflow", sb_exp.size(), 1);
        end else begin
            chk(sb_tag.pop_front(), got, sb_exp.pop_front());
        end
    endtask

    task automatic expect_eq(input string tag, input int got, input int exp);
        sb_push(tag, exp);
        sb_pop(got);
    endtask

    function automatic bit cond_met(input int sel);
        case (sel)
            W_RST_LO:  return (pll_rst == 1'b0);
            W_RDY_HI:  return (clk_ready == 1'b1);
            W_LOST_HI: return (lock_lost == 1'b1);
            W_FAIL_HI: return (pll_fail == 1'b1);
            default:   return 1'b0;
        endcase
    endfunction

    // Advances cycle by cycle (sampling at negedge) until the condition holds; stamp is the
    // cycle number at which it was seen, or -1 if the bound expired.
    task automatic wait_until(input int sel, input int bound, output int stamp);
        stamp = -1;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (cond_met(sel)) begin
                stamp = cyc;
                break;
            end
        end
    endtask

    initial begin
        int t, t0, td, tr, tg, ts, ll_snap, rise_snap;
        n_vec = 0; n_err = 0; cyc = 0; ll_cnt = 0; rdy_rises = 0;
        rst = 1'b1; pll_lock = 1'b0; soft_rst_req = 1'b0;
        repeat (2) @(negedge clk);

        // reset state
        expect_eq("rst_pll_rst",   int'(pll_rst),   1);
        expect_eq("rst_clk_ready", int'(clk_ready), 0);
        expect_eq("rst_lock_lost", int'(lock_lost), 0);
        expect_eq("rst_retry",     int'(retry_cnt), 0);
        expect_eq("rst_fail",      int'(pll_fail),  0);
        expect_eq("rst_state",     int'(state_o),   int'(RESET));

        // 1: release, lock arrives later, ready after sync + stable window
        rst = 1'b0; t0 = cyc;
        sb_push("s1_rst_fall", t0 + RST_HOLD_CYC);
        wait_until(W_RST_LO, 50, t); sb_pop(t);
        while (cyc < t0 + 9) @(negedge clk);
        pll_lock = 1'b1; t = cyc;
        sb_push("s1_ready_rise", t + 1 + SYNC_STAGES + LOCK_STABLE_CYC);
        wait_until(W_RDY_HI, 100, t); sb_pop(t);
        expect_eq("s1_retry",  int'(retry_cnt), 0);
        expect_eq("s1_lost",   ll_cnt, 0);
        expect_eq("s1_state",  int'(state_o), int'(RUN));
        expect_eq("s1_pll_rst", int'(pll_rst), 0);

        // 2: lock drop in RUN for 5 cycles
        repeat (3) @(negedge clk);
        pll_lock = 1'b0; td = cyc;
        sb_push("s2_lost_at", td + SYNC_STAGES + 1);
        wait_until(W_LOST_HI, 20, t); sb_pop(t);
        expect_eq("s2_ready_drop", int'(clk_ready), 0);
        @(negedge clk);
        expect_eq("s2_lost_width", int'(lock_lost), 0);
        expect_eq("s2_pll_rst_on", int'(pll_rst),   1);
        expect_eq("s2_retry",      int'(retry_cnt), 1);
        tr = cyc;
        @(negedge clk);
        pll_lock = 1'b1;
        sb_push("s2_rst_hold", tr + RST_HOLD_CYC);
        wait_until(W_RST_LO, 50, t); sb_pop(t);

        // 4: one-cycle lock glitch while in STABLE
        repeat (3) @(negedge clk);
        pll_lock = 1'b0; tg = cyc;
        @(negedge clk);
        pll_lock = 1'b1;
        sb_push("s4_back_to_wait", int'(WAIT_LOCK));
        repeat (2) @(negedge clk);
        sb_pop(int'(state_o));
        sb_push("s4_ready_rise", tg + SYNC_STAGES + 2 + LOCK_STABLE_CYC);
        wait_until(W_RDY_HI, 100, t); sb_pop(t);
        expect_eq("s4_retry", int'(retry_cnt), 1);
        expect_eq("s4_lost",  ll_cnt, 1);

        // soft restart from RUN with lock removed, then 3: retries exhausted
        repeat (2) @(negedge clk);
        soft_rst_req = 1'b1; pll_lock = 1'b0; ts = cyc; ll_snap = ll_cnt;
        @(negedge clk);
        soft_rst_req = 1'b0;
        expect_eq("sr_state",   int'(state_o),   int'(RESET));
        expect_eq("sr_ready",   int'(clk_ready), 0);
        expect_eq("sr_retry",   int'(retry_cnt), 0);
        expect_eq("sr_pll_rst", int'(pll_rst),   1);
        sb_push("s3_fail_at", ts + 1 + (MAX_RETRY + 1) * (RST_HOLD_CYC + LOCK_TIMEOUT_CYC + 1));
        wait_until(W_FAIL_HI, 300, t); sb_pop(t);
        expect_eq("s3_pll_rst", int'(pll_rst),   1);
        expect_eq("s3_retry",   int'(retry_cnt), MAX_RETRY);
        expect_eq("s3_state",   int'(state_o),   int'(FAIL));
        expect_eq("s3_no_lost", ll_cnt, ll_snap);
        repeat (5) @(negedge clk);
        expect_eq("s3_fail_sticky", int'(pll_fail), 1);
        expect_eq("s3_rst_held",    int'(pll_rst),  1);

        // 5: soft restart out of FAIL, normal lock
        pll_lock = 1'b1; soft_rst_req = 1'b1; ts = cyc;
        @(negedge clk);
        soft_rst_req = 1'b0;
        expect_eq("s5_fail_clr",  int'(pll_fail),  0);
        expect_eq("s5_retry_clr", int'(retry_cnt), 0);
        expect_eq("s5_state",     int'(state_o),   int'(RESET));
        sb_push("s5_ready_rise", ts + 1 + RST_HOLD_CYC + 1 + LOCK_STABLE_CYC);
        wait_until(W_RDY_HI, 100, t); sb_pop(t);

        // 6: asynchronous reset in the middle of STABLE
        repeat (2) @(negedge clk);
        soft_rst_req = 1'b1; ts = cyc;
        @(negedge clk);
        soft_rst_req = 1'b0;
        expect_eq("s6_ready_off", int'(clk_ready), 0);
        rise_snap = rdy_rises;
        while (cyc < ts + 9) @(negedge clk);
        expect_eq("s6_in_stable", int'(state_o), int'(STABLE));
        #2 rst = 1'b1;
        #1;
        expect_eq("s6_async_pll_rst", int'(pll_rst),   1);
        expect_eq("s6_async_ready",   int'(clk_ready), 0);
        expect_eq("s6_async_state",   int'(state_o),   int'(RESET));
        expect_eq("s6_async_lost",    int'(lock_lost), 0);
        expect_eq("s6_async_fail",    int'(pll_fail),  0);
        repeat (3) @(negedge clk);
        expect_eq("s6_hold_state", int'(state_o),  int'(RESET));
        expect_eq("s6_no_glitch",  rdy_rises, rise_snap);
        rst = 1'b0; tr = cyc;
        sb_push("s6_ready_rise", tr + RST_HOLD_CYC + 1 + LOCK_STABLE_CYC);
        wait_until(W_RDY_HI, 100, t); sb_pop(t);
        expect_eq("sb_drained", sb_exp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", cyc);
        $fatal(1);
    end

endmodule
